// File: rtl/gate_seq_pkg.sv
// rtl/gate_seq_pkg.sv - shared types and constants for the gate self-test sequencer
package gate_seq_pkg;

  localparam int VEC_W    = 3;
  localparam int SETTLE_W = 4;
  localparam int ERR_MAX  = 15;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    DRIVE  = 3'd1,
    SETTLE = 3'd2,
    CHECK  = 3'd3,
    DONE   = 3'd4
  } state_t;

endpackage

// File: rtl/gate_seq_checker.sv
// rtl/gate_seq_checker.sv - expected-vs-sampled compare for the gate datapath
module gate_seq_checker (
  input  logic drive_a,
  input  logic drive_b,
  input  logic drive_e,
  input  logic sample_c,
  input  logic sample_d,
  output logic mismatch
);

  // Expected values come from the registered drive bits, not from the index.
  always_comb begin
    mismatch = (sample_c != (drive_a & drive_b)) | (sample_d != ~drive_e);
  end

endmodule

// File: rtl/gate_seq_ctrl.sv
// rtl/gate_seq_ctrl.sv - self-test sequencer walking all {a,b,e} vectors through the gate datapath
module gate_seq_ctrl
  import gate_seq_pkg::*;
#(
  parameter int NUM_VEC    = 8,
  parameter int SETTLE_CYC = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       abort,
  input  logic       sample_c,
  input  logic       sample_d,
  output logic       drive_a,
  output logic       drive_b,
  output logic       drive_e,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [3:0] err_cnt,
  output logic       fail_valid,
  output logic [2:0] fail_idx
);

  localparam logic [VEC_W-1:0]    LAST_IDX   = VEC_W'(NUM_VEC - 1);
  localparam logic [SETTLE_W-1:0] SETTLE_LD  = SETTLE_W'(SETTLE_CYC);
  localparam logic [3:0]          ERR_SAT    = 4'(ERR_MAX);

  state_t              state;
  state_t              state_nxt;
  logic [VEC_W-1:0]    vec_idx;
  logic [SETTLE_W-1:0] settle_cnt;
  logic                mismatch;

  gate_seq_checker u_checker (
    .drive_a  (drive_a),
    .drive_b  (drive_b),
    .drive_e  (drive_e),
    .sample_c (sample_c),
    .sample_d (sample_d),
    .mismatch (mismatch)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state and status decode; abort only acts while a run is in flight.
  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (start && !abort) state_nxt = DRIVE;
      end
      DRIVE: begin
        busy      = 1'b1;
        state_nxt = abort ? IDLE : SETTLE;
      end
      SETTLE: begin
        busy = 1'b1;
        if (abort)                 state_nxt = IDLE;
        else if (settle_cnt <= SETTLE_W'(1)) state_nxt = CHECK;
      end
      CHECK: begin
        busy = 1'b1;
        if (abort)                   state_nxt = IDLE;
        else if (vec_idx == LAST_IDX) state_nxt = DONE;
        else                          state_nxt = DRIVE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath: drive registers, settle timer, vector index and result tracking.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      drive_a    <= 1'b0;
      drive_b    <= 1'b0;
      drive_e    <= 1'b0;
      vec_idx    <= '0;
      settle_cnt <= '0;
      err_cnt    <= '0;
      fail_valid <= 1'b0;
      fail_idx   <= '0;
      pass       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (state_nxt == DRIVE) begin
            vec_idx    <= '0;
            err_cnt    <= '0;
            fail_valid <= 1'b0;
            fail_idx   <= '0;
            pass       <= 1'b0;
          end
        end
        DRIVE: begin
          {drive_a, drive_b, drive_e} <= vec_idx;
          settle_cnt                  <= SETTLE_LD;
        end
        SETTLE: begin
          if (settle_cnt != '0) settle_cnt <= settle_cnt - SETTLE_W'(1);
        end
        CHECK: begin
          // A mismatch seen in the same cycle as abort is still recorded.
          if (mismatch) begin
            if (err_cnt != ERR_SAT) err_cnt <= err_cnt + 4'd1;
            if (!fail_valid) begin
              fail_valid <= 1'b1;
              fail_idx   <= vec_idx;
            end
          end
          if (state_nxt == DRIVE) vec_idx <= vec_idx + VEC_W'(1);
        end
        DONE: begin
          pass <= (err_cnt == 4'd0);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/gate_seq_ctrl.md
Name: gate_seq_ctrl

Overview:
Self-test sequencer for the basic gate datapath (c = a & b, d = ~e). On start, it walks a vector index through every {a,b,e} combination and drives the datapath inputs. It waits a programmable settle time, samples c/d and compares them against expected values. It reports an error count, the first failing vector and a pass flag. It sits beside the gate datapath as its only driver and observer.

Parameters:
NUM_VEC, 8, number of vectors applied (1..8); vector i drives {a,b,e} = i[2:0]
SETTLE_CYC, 2, cycles to wait after driving before sampling (1..15)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-high reset
start  in  1  begin a run; sampled only in IDLE
abort  in  1  cancel a run; return to IDLE
sample_c  in  1  datapath output c
sample_d  in  1  datapath output d
drive_a  out  1  datapath input a
drive_b  out  1  datapath input b
drive_e  out  1  datapath input e
busy  out  1  high in DRIVE/SETTLE/CHECK
done  out  1  one-cycle pulse at end of a completed run
pass  out  1  err_cnt==0 at last completed run; held until next start
err_cnt  out  4  mismatching vectors this run, saturates at 15
fail_valid  out  1  at least one mismatch this run
fail_idx  out  3  index of first mismatching vector

Behaviour:
- Reset (async assert, deassert sync to clk): state=IDLE; all outputs 0; vector index=0; settle counter=0.
- States: IDLE, DRIVE, SETTLE, CHECK, DONE.
- IDLE: start=1 and abort=0 -> DRIVE. Clear err_cnt, fail_valid, fail_idx and pass; set index=0. abort=1 wins over start.
- DRIVE (1 cycle): register drive_a/b/e = index[2:0]. Load settle counter with SETTLE_CYC. Go to SETTLE.
- SETTLE: decrement the counter each cycle. After SETTLE_CYC cycles, go to CHECK.
- CHECK (1 cycle): expected c = a&b, d = ~e, computed from the registered drive values. Mismatch on c or d increments err_cnt, saturating at 15 with no wrap. On the first mismatch, set fail_valid=1 and fail_idx=index. If index==NUM_VEC-1, go to DONE. Otherwise increment index and go to DRIVE.
- DONE (1 cycle): done=1; pass=(err_cnt==0); then go to IDLE.
- Timing: each vector occupies SETTLE_CYC+2 cycles. With start captured at edge k, done is high in cycle k+1+NUM_VEC*(SETTLE_CYC+2). With defaults, done is high 33 cycles after the start edge.
- drive_* hold their last value in IDLE/DONE and after abort.
- start while busy: ignored; no restart, no counter clear.
- abort in DRIVE/SETTLE/CHECK: go to IDLE on the next edge. No done pulse; pass stays 0. err_cnt/fail_* keep their partial values. A mismatch in the CHECK cycle where abort is seen is still counted.
- abort in DONE: ignored; the done pulse and pass update still occur.
- rst mid-run: immediate return to reset values, including drive_*.
- Index width is 3 bits. NUM_VEC=8 uses the full range; no wrap occurs because CHECK exits at NUM_VEC-1.

Decomposition:
- Shared package gate_seq_pkg: state enum (IDLE, DRIVE, SETTLE, CHECK, DONE), ERR_MAX=15, VEC_W=3, SETTLE_W=4.
- One natural sub-module: gate_seq_checker, a combinational expected-vs-sampled compare producing a mismatch bit.
- Everything else stays in gate_seq_ctrl.

Test Plan:
- Fault-free datapath model, defaults: pulse start -> busy for 32 cycles, done at cycle 33, pass=1, err_cnt=0, fail_valid=0; drive sequence 000..111.
- c stuck-at-0 -> vectors 6 and 7 fail: err_cnt=2, fail_idx=6, fail_valid=1, pass=0.
- d stuck-at-1 -> odd vectors (e=1) fail: err_cnt=4, fail_idx=1, pass=0. Repeat with NUM_VEC=3 -> err_cnt=1, done at cycle 13.
- abort asserted at cycle 10 -> IDLE next edge, no done, pass=0, busy=0. start asserted 5 cycles later runs a full clean pass with counters cleared.
- start re-pulsed at cycle 5 while busy -> ignored; done still at cycle 33. start+abort together in IDLE -> stays IDLE.
- rst asserted asynchronously mid-SETTLE (between clock edges) -> all outputs 0 immediately; after deassert, a new start completes normally.
